// File: rtl/evt_dispatch_sched.sv
// Event pending/overflow tracker with a single-offer dispatch FSM.
// Optional EVT_DISP_RR_EN: round-robin selection instead of fixed priority.
module evt_dispatch_sched #(
    parameter  int NB_EVT = 8,
    localparam int IDX_W  = $clog2(NB_EVT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NB_EVT-1:0] evt_i,
    input  logic [NB_EVT-1:0] mask_i,
    input  logic              clr_ovf_i,
    output logic              req_valid_o,
    output logic [IDX_W-1:0]  req_idx_o,
    input  logic              req_ready_i,
    output logic [NB_EVT-1:0] pending_o,
    output logic [NB_EVT-1:0] ovf_o,
    output logic              busy_o
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t state;

    logic [NB_EVT-1:0] elig;
    logic [NB_EVT-1:0] clr_vec;
    logic [NB_EVT-1:0] pend_n;
    logic [NB_EVT-1:0] ovf_n;
    logic [IDX_W-1:0]  sel;
    logic              found;
    logic              hs;

`ifdef EVT_DISP_RR_EN
    logic [IDX_W-1:0] ptr;
`endif

    assign hs   = (state == OFFER) && req_ready_i;
    assign elig = pending_o & mask_i;

    always_comb begin
        clr_vec = '0;
        if (hs) begin
            clr_vec[req_idx_o] = 1'b1;
        end
        pend_n = (pending_o & ~clr_vec) | evt_i;
        ovf_n  = clr_ovf_i ? '0 : ovf_o;
        ovf_n  = ovf_n | (evt_i & pending_o & ~clr_vec);
    end

    always_comb begin
        sel   = '0;
        found = |elig;
`ifdef EVT_DISP_RR_EN
        // Later iterations overwrite: k = 1 (ptr-1) has highest priority.
        for (int k = NB_EVT; k >= 1; k--) begin
            if (elig[IDX_W'((int'(ptr) + NB_EVT - k) % NB_EVT)]) begin
                sel = IDX_W'((int'(ptr) + NB_EVT - k) % NB_EVT);
            end
        end
`else
        for (int i = 0; i < NB_EVT; i++) begin
            if (elig[i]) begin
                sel = IDX_W'(i);
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_o <= '0;
            ovf_o     <= '0;
        end else begin
            pending_o <= pend_n;
            ovf_o     <= ovf_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_valid_o <= 1'b0;
            req_idx_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en_i && found) begin
                        state       <= OFFER;
                        req_valid_o <= 1'b1;
                        req_idx_o   <= sel;
                        busy_o      <= 1'b1;
                    end
                end
                OFFER: begin
                    if (req_ready_i) begin
                        state       <= IDLE;
                        req_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

`ifdef EVT_DISP_RR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= req_idx_o;
        end
    end
`endif

endmodule

// File: doc/evt_dispatch_sched.md
Name: evt_dispatch_sched

Overview:
Schedules pending hardware events for the cluster event unit.
- Latches single-cycle event pulses from NB_EVT sources into a pending vector.
- Picks one eligible (pending and unmasked) event with a find-last-one priority scan, highest index first.
- Offers the picked index on a valid/ready port to the downstream dispatcher (core wake-up / IRQ ID logic).
- Sits between the event sources and the per-core event buffers; it owns sequencing and fairness of the shared dispatch path.

Parameters:
- NB_EVT, 8, number of event sources (>= 2, need not be a power of two).
- IDX_W, $clog2(NB_EVT), derived width of the event index; not overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  dispatch enable; when low, no new offers are started.
- evt_i  in  NB_EVT  event pulses; each high cycle on a bit is one event.
- mask_i  in  NB_EVT  1 = source eligible for dispatch.
- clr_ovf_i  in  1  clears all overflow flags.
- req_valid_o  out  1  offer valid.
- req_idx_o  out  IDX_W  offered event index.
- req_ready_i  in  1  downstream accepts the offer.
- pending_o  out  NB_EVT  pending vector (registered).
- ovf_o  out  NB_EVT  sticky overflow flags.
- busy_o  out  1  FSM in OFFER state.

Behaviour:
- Reset (async, rst_i high): pending = 0, ovf = 0, FSM = IDLE, req_valid_o = 0, req_idx_o = 0, busy_o = 0, RR pointer = 0.
- Pending update per bit i, at the clock edge:
  - set if evt_i[i] = 1;
  - cleared if the handshake completes on index i and evt_i[i] = 0;
  - handshake on i with evt_i[i] = 1 in the same cycle: bit stays set, no overflow.
- Overflow: evt_i[i] = 1 while pending[i] = 1 and i is not being cleared that cycle sets ovf[i]. clr_ovf_i clears all ovf bits. A set and a clear in the same cycle: set wins.
- Eligible vector = pending & mask_i. Selection is combinational: highest set index wins. An all-zero eligible vector means no selection; index 0 is a valid selection.
- FSM states:
  - IDLE: if en_i and eligible != 0, register the selected index into req_idx_o and go to OFFER.
  - OFFER: req_valid_o = 1. req_idx_o is held stable until req_ready_i = 1. The handshake occurs at the clock edge with req_valid_o & req_ready_i; then return to IDLE.
  - While in OFFER, changes to mask_i or en_i do not revoke or alter the offer.
- Latency:
  - evt_i pulse in cycle n -> pending set at edge n+1 -> req_valid_o high after edge n+2 (en_i = 1, bit unmasked, FSM in IDLE).
  - The mandatory IDLE cycle after each handshake gives a maximum throughput of 1 grant per 2 cycles.
- A masked pending event stays pending indefinitely; unmasking makes it eligible in the next IDLE cycle.
- busy_o = (state == OFFER). pending_o and ovf_o are direct register outputs.

Optional Feature:
EVT_DISP_RR_EN
- Defined: round-robin selection.
  - A registered pointer ptr (reset 0) is updated to the granted index on each handshake.
  - Search order is descending starting at (ptr-1) mod NB_EVT, wrapping, ending at ptr.
  - With ptr = 0 the order equals fixed priority (NB_EVT-1 down to 0).
- Undefined: fixed highest-index priority; no pointer register exists.

Test Plan:
1. Reset with evt_i = 0xFF asserted during rst_i -> all outputs 0. Release, pulse evt_i = 0x01 one cycle, mask_i = 0xFF, en_i = 1, req_ready_i = 1 -> req_valid_o = 1 with req_idx_o = 0 two cycles after the pulse; pending_o = 0 after the handshake.
2. Pulse evt_i = 0x92 in one cycle, req_ready_i = 1 -> grants 7, 4, 1 in that order with an IDLE cycle between each (fixed mode). With EVT_DISP_RR_EN and evt_i = 0x92 re-pulsed after each grant -> grants 7, 4, 1, 7.
3. Offer idx 5 active, req_ready_i = 0 for 4 cycles while mask_i toggles to 0x00 -> req_idx_o stays 5 and req_valid_o stays 1; handshake completes once ready rises.
4. pending[3] = 1, pulse evt_i[3] again -> ovf_o = 0x08. Assert clr_ovf_i together with a new evt_i[3] pulse (bit 3 still pending) -> ovf_o stays 0x08. clr_ovf_i alone -> 0x00.
5. Handshake on idx 2 in the same cycle as an evt_i[2] pulse -> pending_o[2] stays 1, no overflow, idx 2 offered again after the IDLE cycle.
6. en_i = 0 with pending 0x10 -> no offer; en_i rises -> offer idx 4 the next cycle. Assert rst_i mid-OFFER -> req_valid_o drops immediately, pending cleared.
